// File: rtl/core_pipe_exec_mdu_if.sv
// Request/response bundle for the execute-stage multiply/divide unit.
//
// Handshake: the requester raises valid with operands, op select and word
// stable, and holds them until the unit has taken them (busy rises, or ready
// pulses for a one-cycle special divide). ready is a single-cycle pulse that
// qualifies result. There is no back-pressure on the result. flush aborts
// whatever is in flight on the next edge and suppresses a ready in that
// same cycle. dbg_state mirrors the internal FSM state for observation.
interface core_pipe_exec_mdu_if #(parameter int XLEN = 64);
  logic            valid;
  logic            flush;
  logic [XLEN-1:0] opr_a;
  logic [XLEN-1:0] opr_b;
  logic            op_mul;
  logic            op_mulh;
  logic            op_mulhsu;
  logic            op_mulhu;
  logic            op_div;
  logic            op_divu;
  logic            op_rem;
  logic            op_remu;
  logic            word;
  logic            ready;
  logic [XLEN-1:0] result;
  logic            busy;
  logic [1:0]      dbg_state;

  modport master (
    output valid, flush, opr_a, opr_b, op_mul, op_mulh, op_mulhsu, op_mulhu,
           op_div, op_divu, op_rem, op_remu, word,
    input  ready, result, busy, dbg_state
  );

  modport slave (
    input  valid, flush, opr_a, opr_b, op_mul, op_mulh, op_mulhsu, op_mulhu,
           op_div, op_divu, op_rem, op_remu, word,
    output ready, result, busy, dbg_state
  );
endinterface

// File: rtl/core_pipe_exec_mdu.sv
// Iterative multiply/divide unit: shift-add multiplier retiring MUL_UNROLL
// bits per cycle and a 1-bit/cycle restoring divider, both on magnitudes with
// sign fix-up at the end. Divide-by-zero and signed overflow finish at once.
module core_pipe_exec_mdu #(
  parameter int XLEN       = 64,
  parameter int MUL_UNROLL = 1
) (
  input logic                 g_clk,
  input logic                 g_resetn,
  core_pipe_exec_mdu_if.slave mdu
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_W = XLEN'($signed(32'h8000_0000));
  localparam logic [1:0] K_MUL = 2'd0, K_DIV = 2'd1, K_SPEC = 2'd2;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_DONE = 2'd3} state_t;
  state_t state_q, state_d;

  logic op_hi, op_any_mul, op_any_div, rem_sel, wd, a_sgn, b_sgn;
  logic a_neg, b_neg, div0, ovf, special, start;
  logic [XLEN-1:0] a_ext, b_ext, mag_a, mag_b, a_wres, spec_res;
  logic [CW-1:0] mul_steps, div_steps;

  logic            wd_q, hi_q, rem_q_sel, neg_q, neg_r_q;
  logic [1:0]      kind_q;
  logic [CW-1:0]   cnt_q;
  logic [2*XLEN-1:0] acc_q, mcand_q, acc_n, prod;
  logic [XLEN-1:0] mplier_q, rem_q, quo_q, divisor_q, spec_q;
  logic [XLEN-1:0] rem_n, quo_n, q_fix, r_fix, raw, final_res;
  logic [XLEN:0]   r_sh, diff;

  // Decode the request and prepare extended operands, magnitudes and specials.
  always_comb begin
    op_hi      = mdu.op_mulh | mdu.op_mulhsu | mdu.op_mulhu;
    op_any_mul = mdu.op_mul | op_hi;
    op_any_div = mdu.op_div | mdu.op_divu | mdu.op_rem | mdu.op_remu;
    rem_sel    = mdu.op_rem | mdu.op_remu;
    wd         = (XLEN == 64) && mdu.word && !op_hi;
    a_sgn      = mdu.op_mulh | mdu.op_mulhsu | mdu.op_div | mdu.op_rem;
    b_sgn      = mdu.op_mulh | mdu.op_div | mdu.op_rem;
    a_ext      = mdu.opr_a;
    b_ext      = mdu.opr_b;
    if (wd) begin
      a_ext = a_sgn ? XLEN'($signed(mdu.opr_a[31:0])) : XLEN'(mdu.opr_a[31:0]);
      b_ext = b_sgn ? XLEN'($signed(mdu.opr_b[31:0])) : XLEN'(mdu.opr_b[31:0]);
    end
    a_neg    = a_sgn & a_ext[XLEN-1];
    b_neg    = b_sgn & b_ext[XLEN-1];
    mag_a    = a_neg ? -a_ext : a_ext;
    mag_b    = b_neg ? -b_ext : b_ext;
    a_wres   = wd ? XLEN'($signed(mdu.opr_a[31:0])) : mdu.opr_a;
    div0     = op_any_div && (b_ext == '0);
    ovf      = (mdu.op_div | mdu.op_rem) && (a_ext == (wd ? MIN_W : MIN_X)) && (b_ext == '1);
    special  = div0 | ovf;
    if (div0) spec_res = rem_sel ? a_wres : '1;
    else      spec_res = rem_sel ? '0 : a_wres;
    mul_steps = wd ? CW'(32 / MUL_UNROLL - 1) : CW'(XLEN / MUL_UNROLL - 1);
    div_steps = wd ? CW'(31) : CW'(XLEN - 1);
    start     = mdu.valid && !mdu.flush && (op_any_mul | op_any_div);
  end

  // One multiply step (MUL_UNROLL bits) and one restoring divide step.
  always_comb begin
    acc_n = acc_q;
    for (int k = 0; k < MUL_UNROLL; k++) begin
      if (mplier_q[k]) acc_n = acc_n + (mcand_q << k);
    end
    r_sh = {rem_q, quo_q[XLEN-1]};
    diff = r_sh - {1'b0, divisor_q};
    if (diff[XLEN]) begin
      rem_n = r_sh[XLEN-1:0];
      quo_n = {quo_q[XLEN-2:0], 1'b0};
    end else begin
      rem_n = diff[XLEN-1:0];
      quo_n = {quo_q[XLEN-2:0], 1'b1};
    end
  end

  // State register.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // Next-state logic; flush overrides starting and completing.
  always_comb begin
    state_d = state_q;
    if (mdu.flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (start) state_d = special ? S_DONE : (op_any_mul ? S_MUL : S_DIV);
        S_MUL:  if (cnt_q == '0) state_d = S_DONE;
        S_DIV:  if (cnt_q == '0) state_d = S_DONE;
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath: capture in IDLE, iterate in MUL/DIV; inputs ignored elsewhere.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      wd_q <= 1'b0; hi_q <= 1'b0; rem_q_sel <= 1'b0; neg_q <= 1'b0; neg_r_q <= 1'b0;
      kind_q <= K_MUL; cnt_q <= '0; acc_q <= '0; mcand_q <= '0; mplier_q <= '0;
      rem_q <= '0; quo_q <= '0; divisor_q <= '0; spec_q <= '0;
    end else if (state_q == S_IDLE) begin
      if (start) begin
        wd_q      <= wd;
        hi_q      <= op_hi;
        rem_q_sel <= rem_sel;
        neg_q     <= a_neg ^ b_neg;
        neg_r_q   <= a_neg;
        kind_q    <= special ? K_SPEC : (op_any_mul ? K_MUL : K_DIV);
        spec_q    <= spec_res;
        cnt_q     <= op_any_mul ? mul_steps : div_steps;
        acc_q     <= '0;
        mcand_q   <= {{XLEN{1'b0}}, mag_a};
        mplier_q  <= mag_b;
        rem_q     <= '0;
        // Word divides shift the 32-bit dividend to the top so 32 steps suffice.
        quo_q     <= wd ? (mag_a << 32) : mag_a;
        divisor_q <= mag_b;
      end
    end else if (state_q == S_MUL) begin
      acc_q    <= acc_n;
      mcand_q  <= mcand_q << MUL_UNROLL;
      mplier_q <= mplier_q >> MUL_UNROLL;
      cnt_q    <= cnt_q - CW'(1);
    end else if (state_q == S_DIV) begin
      rem_q <= rem_n;
      quo_q <= quo_n;
      cnt_q <= cnt_q - CW'(1);
    end
  end

  // Outputs: sign fix-up, result select and word sign extension.
  always_comb begin
    prod  = neg_q ? -acc_q : acc_q;
    q_fix = neg_q ? -quo_q : quo_q;
    r_fix = neg_r_q ? -rem_q : rem_q;
    case (kind_q)
      K_MUL:   raw = hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
      K_DIV:   raw = rem_q_sel ? r_fix : q_fix;
      K_SPEC:  raw = spec_q;
      default: raw = '0;
    endcase
    final_res     = wd_q ? XLEN'($signed(raw[31:0])) : raw;
    mdu.ready     = (state_q == S_DONE) && !mdu.flush;
    mdu.busy      = (state_q != S_IDLE);
    mdu.result    = mdu.ready ? final_res : '0;
    mdu.dbg_state = state_q;
  end

endmodule

// File: tb/tb_core_pipe_exec_mdu.sv
// Bench for core_pipe_exec_mdu: two instances (MUL_UNROLL 1 and 4) share
// operands; directed vectors push expected result and ready cycle into
// per-instance queues, and a negedge monitor pops and compares.
module tb_core_pipe_exec_mdu;
  localparam logic [7:0] OP_MUL = 8'h80, OP_MULH = 8'h40, OP_MULHSU = 8'h20, OP_MULHU = 8'h10;
  localparam logic [7:0] OP_DIV = 8'h08, OP_DIVU = 8'h04, OP_REM = 8'h02, OP_REMU = 8'h01;

  logic g_clk = 1'b0;
  logic g_resetn = 1'b0;
  logic valid1, valid4, flush, word;
  logic [7:0]  ops;
  logic [63:0] opr_a, opr_b;

  logic [63:0] exp_q1[$], exp_q4[$];
  int cyc_q1[$], cyc_q4[$];
  int neg_cnt = 0;
  int n_checks = 0;
  int n_fail = 0;

  core_pipe_exec_mdu_if #(.XLEN(64)) m1();
  core_pipe_exec_mdu_if #(.XLEN(64)) m4();

  assign m1.valid = valid1;   assign m4.valid = valid4;
  assign m1.flush = flush;    assign m4.flush = flush;
  assign m1.opr_a = opr_a;    assign m4.opr_a = opr_a;
  assign m1.opr_b = opr_b;    assign m4.opr_b = opr_b;
  assign m1.word  = word;     assign m4.word  = word;
  assign m1.op_mul = ops[7];  assign m4.op_mul = ops[7];
  assign m1.op_mulh = ops[6]; assign m4.op_mulh = ops[6];
  assign m1.op_mulhsu = ops[5]; assign m4.op_mulhsu = ops[5];
  assign m1.op_mulhu = ops[4];  assign m4.op_mulhu = ops[4];
  assign m1.op_div = ops[3];  assign m4.op_div = ops[3];
  assign m1.op_divu = ops[2]; assign m4.op_divu = ops[2];
  assign m1.op_rem = ops[1];  assign m4.op_rem = ops[1];
  assign m1.op_remu = ops[0]; assign m4.op_remu = ops[0];

  core_pipe_exec_mdu #(.XLEN(64), .MUL_UNROLL(1)) u_dut1 (.g_clk(g_clk), .g_resetn(g_resetn), .mdu(m1.slave));
  core_pipe_exec_mdu #(.XLEN(64), .MUL_UNROLL(4)) u_dut4 (.g_clk(g_clk), .g_resetn(g_resetn), .mdu(m4.slave));

  // Clock
  always #5 g_clk = ~g_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard: on every negedge, any ready must match the queue head.
  always @(negedge g_clk) begin
    neg_cnt++;
    if (m1.ready !== 1'b0) begin
      if (exp_q1.size() == 0) chk("dut1 unexpected ready", 64'(m1.ready), 64'd0);
      else begin
        chk("dut1 result", m1.result, exp_q1.pop_front());
        chk("dut1 ready cycle", 64'(neg_cnt), 64'(cyc_q1.pop_front()));
      end
    end
    if (m4.ready !== 1'b0) begin
      if (exp_q4.size() == 0) chk("dut4 unexpected ready", 64'(m4.ready), 64'd0);
      else begin
        chk("dut4 result", m4.result, exp_q4.pop_front());
        chk("dut4 ready cycle", 64'(neg_cnt), 64'(cyc_q4.pop_front()));
      end
    end
  end

  task automatic wait_empty();
    for (int i = 0; i < 400; i++) begin
      if (exp_q1.size() == 0 && exp_q4.size() == 0) return;
      @(negedge g_clk); #1;
    end
    chk("wait for ready timeout", 64'(exp_q1.size() + exp_q4.size()), 64'd0);
    exp_q1.delete(); exp_q4.delete(); cyc_q1.delete(); cyc_q4.delete();
  endtask

  // Driver: present one op, push expectations, drop valid after the capture edge
  // and scramble operands to show they are no longer sampled.
  task automatic issue(input logic [7:0] o, input logic w, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp, input bit spec, input bit en1, input bit en4,
                       input bit wait_done);
    int n, l1, l4;
    bit is_mul;
    @(negedge g_clk); #1;
    ops = o; word = w; opr_a = a; opr_b = b; valid1 = en1; valid4 = en4;
    is_mul = |o[7:4];
    n  = (w && (o[6:4] == 3'b000)) ? 32 : 64;
    l1 = spec ? 1 : n + 1;
    l4 = spec ? 1 : (is_mul ? n / 4 + 1 : n + 1);
    if (en1) begin exp_q1.push_back(exp); cyc_q1.push_back(neg_cnt + l1); end
    if (en4) begin exp_q4.push_back(exp); cyc_q4.push_back(neg_cnt + l4); end
    @(posedge g_clk); #1;
    valid1 = 1'b0; valid4 = 1'b0;
    opr_a = {$urandom, $urandom}; opr_b = {$urandom, $urandom};
    if (wait_done) wait_empty();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    valid1 = 0; valid4 = 0; flush = 0; word = 0; ops = 0; opr_a = 0; opr_b = 0;
    repeat (3) @(posedge g_clk);
    @(negedge g_clk);
    chk("reset busy1", 64'(m1.busy), 64'd0);
    chk("reset ready1", 64'(m1.ready), 64'd0);
    chk("reset result1", m1.result, 64'd0);
    chk("reset state1", 64'(m1.dbg_state), 64'd0);
    chk("reset busy4", 64'(m4.busy), 64'd0);
    chk("reset result4", m4.result, 64'd0);
    #1 g_resetn = 1'b1;

    // Directed vectors: op, word, a, b, expected, special, en1, en4, wait
    issue(OP_MULHU, 0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 1, 1, 1);
    issue(OP_DIV,  0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1, 1, 1, 1);
    issue(OP_REM,  0, 64'h8000_0000_0000_0000, '1, 64'd0, 1, 1, 1, 1);
    issue(OP_DIVU, 1, 64'h1234_5678_0000_0007, 64'd0, '1, 1, 1, 1, 1);
    issue(OP_REMU, 1, 64'h1234_5678_0000_0007, 64'd0, 64'd7, 1, 1, 1, 1);
    issue(OP_MUL,  1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 0, 1, 1, 1);
    issue(OP_MUL,  0, 64'd3, 64'd5, 64'd15, 0, 1, 1, 1);
    issue(OP_MULH, 0, 64'h8000_0000_0000_0000, 64'd2, '1, 0, 1, 1, 1);
    issue(OP_MULHSU, 0, '1, '1, '1, 0, 1, 1, 1);
    issue(OP_DIVU, 0, 64'd100, 64'd7, 64'd14, 0, 1, 1, 1);
    issue(OP_REMU, 0, 64'd100, 64'd7, 64'd2, 0, 1, 1, 1);
    issue(OP_DIV,  0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 0, 1, 1, 1);
    issue(OP_REM,  0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 0, 1, 1, 1);
    issue(OP_DIV,  1, 64'hDEAD_BEEF_FFFF_FF9C, 64'h1111_1111_0000_0007, 64'hFFFF_FFFF_FFFF_FFF2, 0, 1, 1, 1);
    issue(OP_DIV,  1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, 1, 1, 1);
    issue(OP_REM,  1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'd0, 1, 1, 1, 1);
    issue(OP_DIV,  0, 64'd5, 64'd0, '1, 1, 1, 1, 1);
    issue(OP_REM,  0, 64'd5, 64'd0, 64'd5, 1, 1, 1, 1);
    issue(OP_MUL,  1, 64'h0000_0000_FFFF_FFFF, 64'd3, 64'hFFFF_FFFF_FFFF_FFFD, 0, 1, 1, 1);
    issue(OP_DIVU, 1, 64'h0000_0000_FFFF_FFFF, 64'h10, 64'h0000_0000_0FFF_FFFF, 0, 1, 1, 1);
    issue(OP_MULHU, 1, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 1, 1, 1);

    // Flush mid-divide: no ready, busy drops, then the reissued op completes.
    @(negedge g_clk); #1;
    ops = OP_REM; word = 0; opr_a = 64'hFFFF_FFFF_FFFF_FFF9; opr_b = 64'd2; valid1 = 1; valid4 = 1;
    @(posedge g_clk); #1 valid1 = 0; valid4 = 0;
    repeat (9) @(negedge g_clk);
    #1 flush = 1'b1;
    @(posedge g_clk); #1 flush = 1'b0;
    @(negedge g_clk);
    chk("flush busy1", 64'(m1.busy), 64'd0);
    chk("flush busy4", 64'(m4.busy), 64'd0);
    issue(OP_REM, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, '1, 0, 1, 1, 1);

    // Flush while in DONE suppresses the ready pulse.
    @(negedge g_clk); #1;
    ops = OP_DIV; word = 0; opr_a = 64'd5; opr_b = 64'd0; valid1 = 1; valid4 = 1;
    @(posedge g_clk); #1 valid1 = 0; valid4 = 0; flush = 1'b1;
    @(negedge g_clk);
    chk("flush done state1", 64'(m1.dbg_state), 64'd3);
    chk("flush done ready1", 64'(m1.ready), 64'd0);
    chk("flush done ready4", 64'(m4.ready), 64'd0);
    @(posedge g_clk); #1 flush = 1'b0;
    @(negedge g_clk);
    chk("flush done busy1", 64'(m1.busy), 64'd0);

    // Reset mid-multiply abandons the op silently.
    @(negedge g_clk); #1;
    ops = OP_MUL; word = 0; opr_a = 64'd3; opr_b = 64'd5; valid1 = 1; valid4 = 1;
    @(posedge g_clk); #1 valid1 = 0; valid4 = 0;
    repeat (5) @(negedge g_clk);
    #1 g_resetn = 1'b0;
    @(posedge g_clk); #1 g_resetn = 1'b1;
    @(negedge g_clk);
    chk("midreset busy1", 64'(m1.busy), 64'd0);
    chk("midreset busy4", 64'(m4.busy), 64'd0);
    chk("midreset result1", m1.result, 64'd0);
    repeat (70) @(negedge g_clk);

    // valid with no op selected stays idle.
    #1 ops = 8'h00; valid1 = 1; valid4 = 1;
    repeat (3) @(negedge g_clk);
    chk("noop busy1", 64'(m1.busy), 64'd0);
    chk("noop busy4", 64'(m4.busy), 64'd0);
    #1 valid1 = 0; valid4 = 0;

    // Back-to-back multiplies on the unrolled instance.
    issue(OP_MUL, 0, 64'd3, 64'd5, 64'd15, 0, 0, 1, 0);
    for (int i = 0; i < 40; i++) begin
      @(negedge g_clk); #1;
      if (exp_q4.size() == 0) break;
    end
    ops = OP_MUL; word = 0; opr_a = 64'hFFFF_FFFF_FFFF_FFFD; opr_b = 64'd5; valid4 = 1;
    exp_q4.push_back(64'hFFFF_FFFF_FFFF_FFF1);
    cyc_q4.push_back(neg_cnt + 1 + 17);
    @(posedge g_clk); #1;
    chk("b2b idle busy4", 64'(m4.busy), 64'd0);
    @(posedge g_clk); #1 valid4 = 0; opr_a = {$urandom, $urandom};
    wait_empty();

    repeat (3) @(negedge g_clk);
    chk("leftover expectations", 64'(exp_q1.size() + exp_q4.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
